// File: rtl/debug_router_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// debug_router_pkg: shared types, widths and the lane packing helper
// Rev 1.0
// ------------------------------------------------------------------
package debug_router_pkg;

  localparam int SAMP_W = 12;
  localparam int LANES  = 4;
  localparam int BUF_W  = 128;
  localparam int SRC_W  = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } cap_state_t;

  // Eight 12-bit lanes into 16-bit slots, MSB-aligned; lanes 0-3 are the older beat.
  function automatic logic [BUF_W-1:0] pack96(input logic [SRC_W-1:0] cur,
                                              input logic [SRC_W-1:0] prev);
    logic [2*SRC_W-1:0] beats;
    pack96 = '0;
    beats  = {cur, prev};
    for (int i = 0; i < 2*LANES; i++) begin
      pack96[16*i+4 +: SAMP_W] = beats[SAMP_W*i +: SAMP_W];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/debug_stream_router_if.sv
`default_nettype none
// ------------------------------------------------------------------
// debug_stream_router_if: packed buffer-word stream toward capture
// Rev 1.0
// ------------------------------------------------------------------
interface debug_stream_router_if
  import debug_router_pkg::*;
#(
  parameter int NBUF = 4
);
  logic [NBUF*BUF_W-1:0] buf_tdata;
  logic [NBUF-1:0]       buf_tvalid;

  modport master (output buf_tdata, output buf_tvalid);
  modport slave  (input  buf_tdata, input  buf_tvalid);
endinterface
`default_nettype wire

// File: rtl/debug_pair_packer.sv
`default_nettype none
// ------------------------------------------------------------------
// debug_pair_packer: per-buffer source mux and two-beat word packer
// Rev 1.0
// ------------------------------------------------------------------
module debug_pair_packer
  import debug_router_pkg::*;
#(
  parameter int NSRC  = 8,
  parameter int SEL_W = 3
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NSRC*SRC_W-1:0]  src_i,
  input  logic [SEL_W-1:0]       sel_i,
  input  logic                   decim_i,
  output logic [BUF_W-1:0]       tdata_o,
  output logic                   tvalid_o
);

  logic [SRC_W-1:0] cur;
  logic [SRC_W-1:0] prev_q;
  logic [SEL_W-1:0] sel_q;
  logic             decim_q;
  logic             t_q, t_d;
  logic [BUF_W-1:0] tdata_q;
  logic             tvalid_q, tvalid_d;
  logic             cfg_chg;

  always_comb begin
    cur = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel_i == k[SEL_W-1:0]) cur = src_i[k*SRC_W +: SRC_W];
    end
  end

  // A changed select or mode invalidates the word that mixes old and new beats.
  assign cfg_chg  = (sel_i != sel_q) || (decim_i != decim_q);
  assign t_d      = cfg_chg ? 1'b0 : ~t_q;
  assign tvalid_d = !cfg_chg && (!decim_i || t_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prev_q   <= '0;
      sel_q    <= '0;
      decim_q  <= 1'b0;
      t_q      <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      prev_q   <= cur;
      sel_q    <= sel_i;
      decim_q  <= decim_i;
      t_q      <= t_d;
      tdata_q  <= pack96(cur, prev_q);
      tvalid_q <= tvalid_d;
    end
  end

  assign tdata_o  = tdata_q;
  assign tvalid_o = tvalid_q;

endmodule
`default_nettype wire

// File: rtl/debug_stream_router.sv
`default_nettype none
// ------------------------------------------------------------------
// debug_stream_router: source select/packing per buffer, ACLK phase, capture FSM
// Rev 1.0
// ------------------------------------------------------------------
module debug_stream_router
  import debug_router_pkg::*;
#(
  parameter int NSRC      = 8,
  parameter int NBUF      = 4,
  parameter int NBEAMS    = 2,
  parameter int PHASE_LEN = 3,
  parameter int POSTW     = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NSRC*SRC_W-1:0]         src_i,
  input  logic [NBUF*$clog2(NSRC)-1:0]  sel_i,
  input  logic [NBUF-1:0]               decim_i,
  input  logic [NBEAMS-1:0]             trig_i,
  input  logic [NBEAMS-1:0]             trig_mask_i,
  input  logic                          arm_i,
  input  logic [POSTW-1:0]              post_len_i,
  input  logic                          capture_waiting,
  output logic                          capture_enable,
  output logic                          trigger,
  output logic                          phase_o,
  debug_stream_router_if.master         buf_if
);

  localparam int SEL_W = $clog2(NSRC);
  localparam int PW    = $clog2(PHASE_LEN);
  localparam logic [PW-1:0] PHASE_MAX = PW'(PHASE_LEN - 1);

  logic [NBUF*BUF_W-1:0] tdata;
  logic [NBUF-1:0]       tvalid;

  for (genvar b = 0; b < NBUF; b++) begin : g_buf
    debug_pair_packer #(
      .NSRC  (NSRC),
      .SEL_W (SEL_W)
    ) u_packer (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .src_i    (src_i),
      .sel_i    (sel_i[b*SEL_W +: SEL_W]),
      .decim_i  (decim_i[b]),
      .tdata_o  (tdata[b*BUF_W +: BUF_W]),
      .tvalid_o (tvalid[b])
    );
  end

  assign buf_if.buf_tdata  = tdata;
  assign buf_if.buf_tvalid = tvalid;

  logic [PW-1:0] phase_q, phase_d;

  assign phase_d = (phase_q == PHASE_MAX) ? '0 : phase_q + 1'b1;
  assign phase_o = (phase_q == '0);

  cap_state_t       state_q, state_d;
  logic [POSTW-1:0] cnt_q, cnt_d;
  logic             trig_q, trig_d;
  logic             enable_q, enable_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trig_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm_i && capture_waiting) state_d = ARMED;
      end
      ARMED: begin
        // Dropping arm wins over a coincident trigger.
        if (!arm_i) begin
          state_d = IDLE;
        end else if (|(trig_i & trig_mask_i)) begin
          trig_d  = 1'b1;
          cnt_d   = post_len_i;
          state_d = POST;
        end
      end
      POST: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        if (capture_waiting && !arm_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enable_d = (state_d == ARMED) || (state_d == POST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      trig_q   <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      trig_q   <= trig_d;
      enable_q <= enable_d;
    end
  end

  assign capture_enable = enable_q;
  assign trigger        = trig_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_stream_router.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// tb_debug_stream_router: directed stimulus with a queued scoreboard
// Rev 1.0
// ------------------------------------------------------------------
module tb_debug_stream_router;
  import debug_router_pkg::*;

  localparam int NSRC      = 8;
  localparam int NBUF      = 4;
  localparam int NBEAMS    = 2;
  localparam int PHASE_LEN = 3;
  localparam int POSTW     = 16;
  localparam int SEL_W     = 3;

  logic                     aclk = 1'b0;
  logic                     aresetn = 1'b0;
  logic [NSRC*SRC_W-1:0]    src_i;
  logic [NBUF*SEL_W-1:0]    sel_i;
  logic [NBUF-1:0]          decim_i;
  logic [NBEAMS-1:0]        trig_i;
  logic [NBEAMS-1:0]        trig_mask_i;
  logic                     arm_i;
  logic [POSTW-1:0]         post_len_i;
  logic                     capture_waiting;
  logic                     capture_enable;
  logic                     trigger;
  logic                     phase_o;

  debug_stream_router_if #(.NBUF(NBUF)) buf_if ();

  debug_stream_router #(
    .NSRC(NSRC), .NBUF(NBUF), .NBEAMS(NBEAMS), .PHASE_LEN(PHASE_LEN), .POSTW(POSTW)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .src_i           (src_i),
    .sel_i           (sel_i),
    .decim_i         (decim_i),
    .trig_i          (trig_i),
    .trig_mask_i     (trig_mask_i),
    .arm_i           (arm_i),
    .post_len_i      (post_len_i),
    .capture_waiting (capture_waiting),
    .capture_enable  (capture_enable),
    .trigger         (trigger),
    .phase_o         (phase_o),
    .buf_if          (buf_if)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic                  en;
    logic                  trg;
    logic                  ph;
    logic [NBUF-1:0]       v;
    logic [NBUF*BUF_W-1:0] d;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lastchg[NBUF];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Source k, cycle c, lane j -> {k, c, j}: every sample identifies its origin.
  function automatic logic [11:0] srcval(input int k, input int c, input int j);
    logic [2:0] kk;
    logic [6:0] cc;
    logic [1:0] jj;
    kk = k[2:0];
    cc = c[6:0];
    jj = j[1:0];
    return {kk, cc, jj};
  endfunction

  function automatic logic [127:0] expword(input int selc, input int c, input int selp, input bit havep);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (havep) w[16*i+4 +: 12] = srcval(selp, c - 1, i);
      w[16*(i+4)+4 +: 12] = srcval(selc, c, i);
    end
    return w;
  endfunction

  function automatic int cfg_sel(input int seg, input int b, input int c);
    if (seg == 0) begin
      case (b)
        0:       return (c < 10) ? 0 : 3;
        1:       return 1;
        2:       return 5;
        default: return (c == 15) ? 6 : 7;
      endcase
    end
    case (b)
      0:       return 0;
      1:       return 2;
      2:       return 4;
      default: return 7;
    endcase
  endfunction

  function automatic bit cfg_dec(input int seg, input int b, input int c);
    if (seg == 0 && b == 0) return c >= 30;
    return b == 1;
  endfunction

  // Hand-derived capture timeline, indexed by output cycle m.
  function automatic bit exp_en(input int seg, input int m);
    if (seg == 0) return (m >= 6 && m <= 26) || m == 37 || m == 38 || m >= 41;
    return m >= 5 && m <= 7;
  endfunction

  function automatic bit exp_trg(input int seg, input int m);
    if (seg == 0) return m == 21 || m == 43;
    return m == 7;
  endfunction

  task automatic drive(input int seg, input int c);
    exp_t e;
    int   sn, sp, tmp;
    bit   dn, dp, chg;
    @(negedge aclk);
    for (int k = 0; k < NSRC; k++)
      for (int j = 0; j < LANES; j++)
        src_i[k*SRC_W + j*SAMP_W +: SAMP_W] = srcval(k, c, j);
    for (int b = 0; b < NBUF; b++) begin
      tmp = cfg_sel(seg, b, c);
      sel_i[b*SEL_W +: SEL_W] = tmp[SEL_W-1:0];
      decim_i[b] = cfg_dec(seg, b, c);
    end
    trig_mask_i = 2'b10;
    if (seg == 0) begin
      capture_waiting = !(c == 34 || c == 35);
      arm_i           = (c >= 5 && c < 32) || (c >= 34 && c < 38) || (c >= 40);
      post_len_i      = 16'd5;
      trig_i          = (c == 2 || c == 5 || c == 20 || c == 23 || c == 29 || c == 42) ? 2'b10 :
                        (c == 8) ? 2'b01 : 2'b00;
    end else begin
      capture_waiting = 1'b1;
      arm_i           = c >= 4;
      post_len_i      = 16'd0;
      trig_i          = (c == 1 || c == 6) ? 2'b10 : 2'b00;
    end
    if (c == 0) aresetn = 1'b1;

    for (int b = 0; b < NBUF; b++) begin
      sn = cfg_sel(seg, b, c);
      dn = cfg_dec(seg, b, c);
      sp = (c == 0) ? 0 : cfg_sel(seg, b, c - 1);
      dp = (c == 0) ? 1'b0 : cfg_dec(seg, b, c - 1);
      chg = (sn != sp) || (dn != dp);
      if (chg) lastchg[b] = c;
      e.v[b] = !chg && (!dn || (((c + 1 - lastchg[b]) % 2) == 1));
      e.d[b*BUF_W +: BUF_W] = expword(sn, c, sp, c > 0);
    end
    e.en  = exp_en(seg, c + 1);
    e.trg = exp_trg(seg, c + 1);
    e.ph  = ((c + 1) % PHASE_LEN) == 0;
    expq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge aclk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("capture_enable", {127'd0, capture_enable}, {127'd0, e.en});
        chk("trigger", {127'd0, trigger}, {127'd0, e.trg});
        chk("phase_o", {127'd0, phase_o}, {127'd0, e.ph});
        for (int b = 0; b < NBUF; b++) begin
          chk($sformatf("tvalid[%0d]", b), {127'd0, buf_if.buf_tvalid[b]}, {127'd0, e.v[b]});
          if (e.v[b])
            chk($sformatf("tdata[%0d]", b), buf_if.buf_tdata[b*BUF_W +: BUF_W], e.d[b*BUF_W +: BUF_W]);
        end
      end
    end
  end

  initial begin : stimulus
    src_i = '0; sel_i = '0; decim_i = '0; trig_i = '0; trig_mask_i = '0;
    arm_i = 1'b0; post_len_i = '0; capture_waiting = 1'b1;

    repeat (2) @(posedge aclk);
    #1;
    chk("rst capture_enable", {127'd0, capture_enable}, 128'd0);
    chk("rst trigger", {127'd0, trigger}, 128'd0);
    chk("rst phase_o", {127'd0, phase_o}, 128'd1);
    chk("rst tvalid", {124'd0, buf_if.buf_tvalid}, 128'd0);
    for (int b = 0; b < NBUF; b++)
      chk($sformatf("rst tdata[%0d]", b), buf_if.buf_tdata[b*BUF_W +: BUF_W], 128'd0);

    for (int b = 0; b < NBUF; b++) lastchg[b] = -1;
    for (int c = 0; c < 45; c++) drive(0, c);

    // Mid-POST: reset between edges must clear registered outputs at once.
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    chk("async capture_enable", {127'd0, capture_enable}, 128'd0);
    chk("async trigger", {127'd0, trigger}, 128'd0);
    chk("async phase_o", {127'd0, phase_o}, 128'd1);
    chk("async tvalid", {124'd0, buf_if.buf_tvalid}, 128'd0);
    chk("async tdata[0]", buf_if.buf_tdata[0 +: BUF_W], 128'd0);

    for (int b = 0; b < NBUF; b++) lastchg[b] = -1;
    for (int c = 0; c < 10; c++) drive(1, c);

    for (int i = 0; i < 5 && expq.size() != 0; i++) begin
      @(posedge aclk);
      #2;
    end
    if (expq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", expq.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
